// File: rtl/pipelined_alu_pkg.sv
// Shared opcode encodings, FSM states and flag bundle for the pipelined ALU.
// Encodings 0..7 match the legacy combinational ALU.
package pipelined_alu_pkg;

    localparam logic [3:0] ADD_ALU  = 4'd0;
    localparam logic [3:0] SUB_ALU  = 4'd1;
    localparam logic [3:0] SLT_ALU  = 4'd2;
    localparam logic [3:0] AND_ALU  = 4'd3;
    localparam logic [3:0] OR_ALU   = 4'd4;
    localparam logic [3:0] NOR_ALU  = 4'd5;
    localparam logic [3:0] SLL_ALU  = 4'd6;
    localparam logic [3:0] SRL_ALU  = 4'd7;
    localparam logic [3:0] SRA_ALU  = 4'd8;
    localparam logic [3:0] XOR_ALU  = 4'd9;
    localparam logic [3:0] SLTU_ALU = 4'd10;
    localparam logic [3:0] MUL_ALU  = 4'd11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MUL_RUN = 2'd1,
        ST_DONE    = 2'd2
    } state_e;

    typedef struct packed {
        logic zero;
        logic neg;
        logic carry;
        logic overflow;
    } flags_t;

    // Opcodes above MUL_ALU are reserved and complete as illegal.
    function automatic logic is_legal_op(input logic [3:0] op);
        return op <= MUL_ALU;
    endfunction

endpackage

// File: rtl/pipelined_alu_mul_iter.sv
// Radix-2 shift-add unsigned multiplier: one iteration per cycle for WIDTH cycles.
// done/product are combinational and show the final iteration's value in its cycle.
module mul_iter #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CNT_W = $clog2(WIDTH);

    logic                busy_q;
    logic [CNT_W-1:0]    count_q;
    logic [WIDTH-1:0]    mcand_q;
    logic [2*WIDTH-1:0]  acc_q;
    logic [WIDTH:0]      partial;
    logic [2*WIDTH-1:0]  acc_next;

    // acc holds {high partial sum, remaining multiplier bits}; each step adds and shifts right.
    always_comb begin
        partial  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
        acc_next = {partial, acc_q[WIDTH-1:1]};
        done     = busy_q && (count_q == CNT_W'(WIDTH - 1));
        product  = acc_next;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q  <= 1'b0;
            count_q <= '0;
        end else if (start) begin
            busy_q  <= 1'b1;
            count_q <= '0;
        end else if (busy_q) begin
            // NOTE: non-blocking so every register samples pre-edge values, independent of statement order.
            count_q <= count_q + CNT_W'(1);
            if (done) begin
                busy_q <= 1'b0;
            end
        end
    end

    // NOTE: datapath registers have no reset; busy_q gates every use, so stale contents are harmless.
    always_ff @(posedge clk) begin
        if (start) begin
            mcand_q <= multiplicand;
            acc_q   <= {{WIDTH{1'b0}}, multiplier};
        end else if (busy_q) begin
            acc_q   <= acc_next;
        end
    end

endmodule

// File: rtl/pipelined_alu.sv
// Handshaked ALU with a registered result stage, NZCV flags and an iterative multiplier.
// Single-cycle ops land in DONE one edge after accept; MUL takes WIDTH iterations.
module pipelined_alu
    import pipelined_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             inValid,
    output logic             inReady,
    input  logic [3:0]       aluCtrl,
    input  logic [WIDTH-1:0] operandA,
    input  logic [WIDTH-1:0] operandB,
    output logic             outValid,
    input  logic             outReady,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] resultHi,
    output logic             zeroFlag,
    output logic             negFlag,
    output logic             carryFlag,
    output logic             overflowFlag,
    output logic             illegalOp
);

    localparam int SHAMT_W = $clog2(WIDTH);

    state_e state_q, state_d;

    logic               accept;
    logic               is_mul;
    logic               is_illegal;
    logic               mul_start;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_product;

    logic [WIDTH:0]     sum_ext;
    logic [WIDTH:0]     diff_ext;
    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0]   alu_result;
    flags_t             alu_flags;

    logic [WIDTH-1:0]   result_q;
    logic [WIDTH-1:0]   result_hi_q;
    flags_t             flags_q;
    logic               illegal_q;

    // The outReady term lets a drain and a new accept share one cycle.
    assign inReady    = (state_q == ST_IDLE) || ((state_q == ST_DONE) && outReady);
    assign accept     = inValid && inReady;
    assign is_mul     = (aluCtrl == MUL_ALU);
    assign is_illegal = !is_legal_op(aluCtrl);
    assign mul_start  = accept && is_mul;

    always_comb begin
        // NOTE: defaults first so every path assigns state_d and no latch is inferred.
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = is_mul ? ST_MUL_RUN : ST_DONE;
                end
            end
            ST_MUL_RUN: begin
                if (mul_done) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (accept) begin
                    state_d = is_mul ? ST_MUL_RUN : ST_DONE;
                end else if (outReady) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Single-cycle datapath; SUB is A + ~B + 1 so carry means "no borrow".
    always_comb begin
        alu_result = '0;
        alu_flags  = '0;
        sum_ext    = {1'b0, operandA} + {1'b0, operandB};
        diff_ext   = {1'b0, operandA} + {1'b0, ~operandB} + (WIDTH+1)'(1);
        shamt      = operandB[SHAMT_W-1:0];
        case (aluCtrl)
            ADD_ALU: begin
                alu_result         = sum_ext[WIDTH-1:0];
                alu_flags.carry    = sum_ext[WIDTH];
                alu_flags.overflow = (operandA[WIDTH-1] == operandB[WIDTH-1]) &&
                                     (sum_ext[WIDTH-1] != operandA[WIDTH-1]);
            end
            SUB_ALU: begin
                alu_result         = diff_ext[WIDTH-1:0];
                alu_flags.carry    = diff_ext[WIDTH];
                alu_flags.overflow = (operandA[WIDTH-1] != operandB[WIDTH-1]) &&
                                     (diff_ext[WIDTH-1] != operandA[WIDTH-1]);
            end
            SLT_ALU:  alu_result = {{(WIDTH-1){1'b0}}, ($signed(operandA) < $signed(operandB))};
            SLTU_ALU: alu_result = {{(WIDTH-1){1'b0}}, (operandA < operandB)};
            AND_ALU:  alu_result = operandA & operandB;
            OR_ALU:   alu_result = operandA | operandB;
            NOR_ALU:  alu_result = ~(operandA | operandB);
            XOR_ALU:  alu_result = operandA ^ operandB;
            SLL_ALU:  alu_result = operandA << shamt;
            SRL_ALU:  alu_result = operandA >> shamt;
            SRA_ALU:  alu_result = $unsigned($signed(operandA) >>> shamt);
            default:  alu_result = '0;
        endcase
        alu_flags.zero = (alu_result == '0);
        alu_flags.neg  = alu_result[WIDTH-1];
    end

    mul_iter #(
        .WIDTH(WIDTH)
    ) u_mul_iter (
        .clk         (clk),
        .rst_n       (rstN),
        .start       (mul_start),
        .multiplicand(operandA),
        .multiplier  (operandB),
        .done        (mul_done),
        .product     (mul_product)
    );

    // Result registers only change on accept or MUL completion, so they hold under back-pressure.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            result_q    <= '0;
            result_hi_q <= '0;
            flags_q     <= '0;
            illegal_q   <= 1'b0;
        end else if (accept) begin
            illegal_q <= is_illegal;
            if (!is_mul) begin
                result_q    <= alu_result;
                result_hi_q <= '0;
                flags_q     <= alu_flags;
            end
        end else if (mul_done) begin
            result_q         <= mul_product[WIDTH-1:0];
            result_hi_q      <= mul_product[2*WIDTH-1:WIDTH];
            flags_q.zero     <= (mul_product == '0);
            flags_q.neg      <= mul_product[WIDTH-1];
            flags_q.carry    <= (mul_product[2*WIDTH-1:WIDTH] != '0);
            flags_q.overflow <= 1'b0;
        end
    end

    assign outValid     = (state_q == ST_DONE);
    assign result       = result_q;
    assign resultHi     = result_hi_q;
    assign zeroFlag     = flags_q.zero;
    assign negFlag      = flags_q.neg;
    assign carryFlag    = flags_q.carry;
    assign overflowFlag = flags_q.overflow;
    assign illegalOp    = illegal_q;

endmodule

// File: doc/pipelined_alu.md
Name: pipelined_alu

Overview:
- Parametrised, handshaked successor to the combinational 8-bit ALU.
- Adds a registered result stage, valid/ready flow control, widened opcode space (SRA, XOR, SLTU, iterative MUL) and full NZCV flags.
- Sits between the register-file read stage and writeback. Back-pressure lets the datapath stall on multi-cycle MUL.

Parameters:
- WIDTH, 8, operand/result width in bits (legal: 4..32).
- SHAMT_W, $clog2(WIDTH), derived localparam: shift-amount bits taken from operandB.

Ports:
- clk  input  1  clock; rising edge.
- rstN  input  1  synchronous active-low reset.
- inValid  input  1  request valid.
- inReady  output  1  block can accept a request this cycle.
- aluCtrl  input  4  opcode.
- operandA  input  WIDTH  signed operand A.
- operandB  input  WIDTH  signed operand B.
- outValid  output  1  result registers hold a valid result.
- outReady  input  1  consumer takes the result this cycle.
- result  output  WIDTH  result (low half for MUL).
- resultHi  output  WIDTH  MUL high half; 0 for all other ops.
- zeroFlag, negFlag, carryFlag, overflowFlag  output  1 each  flags qualified by outValid.
- illegalOp  output  1  opcode 12..15 was accepted.

Behaviour:
- Reset (rstN=0 at an edge): state IDLE; outValid, result, resultHi, all flags, illegalOp = 0. Reset during MUL_RUN aborts the op; no output is produced.
- Opcodes:
  - 0 ADD, 1 SUB, 2 SLT (signed), 3 AND, 4 OR, 5 NOR, 6 SLL, 7 SRL. Encodings 0..7 are unchanged from the legacy ALU.
  - 8 SRA, 9 XOR, 10 SLTU, 11 MUL (unsigned, 2*WIDTH product).
  - 12..15 illegal.
- States:
  - IDLE: waiting for a request.
  - MUL_RUN: shift-add iteration, counter 0..WIDTH-1.
  - DONE: outValid=1.
- Handshake:
  - Accept occurs when inValid & inReady.
  - inReady = (state==IDLE) | (state==DONE & outReady). The combinational path from outReady gives back-to-back throughput.
  - Result drain occurs when outValid & outReady.
  - While outValid=1 and outReady=0, result and all flags hold stable.
- Latency:
  - Single-cycle ops accepted at edge N: result is registered at edge N, state DONE, outValid=1 in the following cycle.
  - MUL accepted at edge N: MUL_RUN, one iteration per cycle. The final iteration at edge N+WIDTH writes result/resultHi and enters DONE.
- Transitions:
  - IDLE -> DONE on a single-cycle accept. IDLE -> MUL_RUN on a MUL accept.
  - MUL_RUN -> DONE after WIDTH iterations. inReady=0 throughout.
  - DONE with drain and a new accept -> DONE or MUL_RUN as above. DONE with drain and no accept -> IDLE.
- Arithmetic:
  - ADD/SUB are computed at WIDTH+1 bits.
  - SUB = A + ~B + 1.
  - carryFlag: ADD carry-out; SUB set when there is no borrow (A>=B unsigned).
  - overflowFlag: signed overflow for ADD/SUB; 0 otherwise.
  - SLT/SLTU result is 1 or 0.
  - Shifts use operandB[SHAMT_W-1:0]. SRA sign-fills. Shift flags C=V=0.
  - MUL: zeroFlag = (full 2*WIDTH product == 0); carryFlag = (resultHi != 0); overflowFlag = 0.
- Flags for all non-MUL ops:
  - zeroFlag = (result == 0).
  - negFlag = result[WIDTH-1].
- Illegal opcode: completes in single-cycle timing with result=0, resultHi=0, zeroFlag=1, other flags 0, illegalOp=1. illegalOp clears on the next accepted legal op.
- Inputs are sampled only at accept. Operand changes during MUL_RUN are ignored.

Decomposition:
- Shared header: opcode macros ADD_ALU..MUL_ALU (4-bit, extending the existing ALU macros) and state encodings.
- Sub-module mul_iter: shift-add multiplier with start/done, WIDTH-cycle iteration, 2*WIDTH product register.
- Top-level block holds the FSM, the combinational single-cycle datapath, the output registers and the flags.

Test Plan:
- WIDTH=8, ADD 0x7F+0x01, outReady=1 -> next cycle outValid=1, result=0x80, N=1, V=1, C=0, Z=0.
- SUB 0x05-0x05, then SUB 0x03-0x05 back-to-back with inValid held:
  - 1st: result=0x00, Z=1, C=1.
  - 2nd: result=0xFE, N=1, C=0.
  - inReady stays 1 throughout; one result per cycle.
- SRA 0x80 by 2 -> 0xE0. SRL 0x80 by 2 -> 0x20. SLL 0x01 by 9 (shamt=1) -> 0x02.
- MUL 0xFF*0xFF -> inReady=0 for 8 cycles, then result=0x01, resultHi=0xFE, C=1, Z=0. A new inValid during MUL_RUN is not accepted.
- Back-pressure: ADD 2+3 with outReady=0 for 5 cycles -> result=0x05 and flags hold stable, inReady=0. When outReady is raised, drain occurs and a queued request is accepted in the same cycle.
- rstN=0 for one edge mid-MUL -> IDLE, outValid=0, all outputs 0, inReady=1 next cycle. Opcode 13 -> result=0, Z=1, illegalOp=1.
